// File: rtl/periph_packet_router.sv
// Packet router between the USB FIFO bridge and the peripheral slots: address-decoded
// host->slot delivery and round-robin slot->host merging with source address stamping.
module periph_packet_router #(
    parameter int NUM_PERIPH = 8,
    parameter int PKT_W      = 32,
    parameter int ADDR_W     = $clog2(NUM_PERIPH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PKT_W-1:0]            usb_rx_data,
    input  logic                        usb_rx_valid,
    output logic                        usb_rx_ready,
    input  logic [NUM_PERIPH-1:0]       periph_en,
    output logic [PKT_W-1:0]            periph_rx_data,
    output logic [NUM_PERIPH-1:0]       periph_rx_valid,
    input  logic [NUM_PERIPH-1:0]       periph_rx_ready,
    input  logic [NUM_PERIPH*PKT_W-1:0] periph_tx_data,
    input  logic [NUM_PERIPH-1:0]       periph_tx_valid,
    output logic [NUM_PERIPH-1:0]       periph_tx_ready,
    output logic [PKT_W-1:0]            usb_tx_data,
    output logic                        usb_tx_valid,
    input  logic                        usb_tx_ready,
    output logic [7:0]                  drop_count
);

    // ---------------- RX path: host -> addressed slot ----------------
    logic              rx_full;
    logic [PKT_W-1:0]  rx_buf;
    logic [ADDR_W-1:0] dest;
    logic              dest_en;
    logic              dest_rdy;
    logic              rx_drain;
    logic              rx_accept;

    assign dest      = rx_buf[PKT_W-1 -: ADDR_W];
    assign dest_en   = periph_en[dest];
    assign dest_rdy  = periph_rx_ready[dest];
    // A disabled destination drains immediately so the host stream never stalls on it.
    assign rx_drain  = rx_full & (~dest_en | dest_rdy);
    assign usb_rx_ready = rst_n & (~rx_full | rx_drain);
    assign rx_accept = usb_rx_valid & usb_rx_ready;
    assign periph_rx_data = rx_buf;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
        periph_rx_valid = '0;
        if (rx_full && dest_en) periph_rx_valid[dest] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full    <= 1'b0;
            // NOTE: data registers are reset too so nothing stale survives a mid-transfer reset.
            rx_buf     <= '0;
            drop_count <= '0;
        end else begin
            if (rx_accept) begin
                rx_buf  <= usb_rx_data;
                rx_full <= 1'b1;
            end else if (rx_drain) begin
                rx_full <= 1'b0;
            end
            if (rx_drain && !dest_en && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    // ---------------- TX path: slots -> host, round robin ----------------
    logic                    tx_full;
    logic [PKT_W-1:0]        tx_buf;
    logic [ADDR_W-1:0]       last_grant;
    logic                    tx_free;
    logic                    grant_valid;
    logic [ADDR_W-1:0]       grant_idx;
    logic [PKT_W-ADDR_W-1:0] grant_payload;
    int                      idx;

    assign tx_free      = ~tx_full | usb_tx_ready;
    assign usb_tx_valid = tx_full;
    assign usb_tx_data  = tx_buf;

    // Search upward from the slot after the last winner; the first requester found wins.
    always_comb begin
        grant_valid   = 1'b0;
        grant_idx     = '0;
        grant_payload = '0;
        idx           = 0;
        for (int k = 1; k <= NUM_PERIPH; k++) begin
            idx = (int'(last_grant) + k) % NUM_PERIPH;
            if (!grant_valid && periph_tx_valid[idx]) begin
                grant_valid   = 1'b1;
                grant_idx     = ADDR_W'(idx);
                grant_payload = periph_tx_data[idx*PKT_W +: (PKT_W-ADDR_W)];
            end
        end
    end

    assign periph_tx_ready = (rst_n && tx_free && grant_valid)
                           ? (NUM_PERIPH'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full    <= 1'b0;
            tx_buf     <= '0;
            last_grant <= ADDR_W'(NUM_PERIPH-1);
        end else if (tx_free) begin
            if (grant_valid) begin
                tx_buf     <= {grant_idx, grant_payload};
                tx_full    <= 1'b1;
                last_grant <= grant_idx;
            end else begin
                tx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_periph_packet_router.sv
// Directed self-checking bench for periph_packet_router with hand-computed expectations.
module tb_periph_packet_router;

    localparam int N = 8;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     usb_rx_data;
    logic             usb_rx_valid;
    logic             usb_rx_ready;
    logic [N-1:0]     periph_en;
    logic [W-1:0]     periph_rx_data;
    logic [N-1:0]     periph_rx_valid;
    logic [N-1:0]     periph_rx_ready;
    logic [N*W-1:0]   periph_tx_data;
    logic [N-1:0]     periph_tx_valid;
    logic [N-1:0]     periph_tx_ready;
    logic [W-1:0]     usb_tx_data;
    logic             usb_tx_valid;
    logic             usb_tx_ready;
    logic [7:0]       drop_count;

    int checks = 0;
    int errors = 0;

    periph_packet_router #(.NUM_PERIPH(N), .PKT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .usb_rx_data(usb_rx_data), .usb_rx_valid(usb_rx_valid), .usb_rx_ready(usb_rx_ready),
        .periph_en(periph_en),
        .periph_rx_data(periph_rx_data), .periph_rx_valid(periph_rx_valid),
        .periph_rx_ready(periph_rx_ready),
        .periph_tx_data(periph_tx_data), .periph_tx_valid(periph_tx_valid),
        .periph_tx_ready(periph_tx_ready),
        .usb_tx_data(usb_tx_data), .usb_tx_valid(usb_tx_valid), .usb_tx_ready(usb_tx_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rx_pkt(input int a);
        logic [2:0] a3;
        a3 = 3'(a);
        return {a3, 29'h0000_1000 + 29'(a)};
    endfunction

    // Raw slot word carries 3'b111 on top so stamping is visible.
    function automatic logic [31:0] tx_raw(input int s);
        return 32'hE000_0011 | (32'(s) << 8);
    endfunction

    function automatic logic [31:0] tx_stamped(input int s);
        logic [31:0] r;
        r = tx_raw(s);
        return {3'(s), r[28:0]};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout reached before end of directed sequence");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        usb_rx_data     = '0;
        usb_rx_valid    = 1'b0;
        periph_en       = 8'hFF;
        periph_rx_ready = 8'hFF;
        periph_tx_valid = 8'h01;
        usb_tx_ready    = 1'b0;
        for (int s = 0; s < N; s++) periph_tx_data[s*W +: W] = tx_raw(s);

        // Reset state
        #2;
        check("rst_usb_rx_ready", 32'(usb_rx_ready), 32'd0);
        check("rst_periph_tx_ready", 32'(periph_tx_ready), 32'd0);
        check("rst_usb_tx_valid", 32'(usb_tx_valid), 32'd0);
        check("rst_periph_rx_valid", 32'(periph_rx_valid), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        periph_tx_valid = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_usb_rx_ready", 32'(usb_rx_ready), 32'd1);

        // Back-to-back host packets to slots 0..7
        for (int i = 0; i < N; i++) begin
            usb_rx_data  = rx_pkt(i);
            usb_rx_valid = 1'b1;
            #1;
            check("b2b_rx_ready", 32'(usb_rx_ready), 32'd1);
            tick();
            check("b2b_rx_valid", 32'(periph_rx_valid), 32'(8'h01 << i));
            check("b2b_rx_data", periph_rx_data, rx_pkt(i));
        end
        usb_rx_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(periph_rx_valid), 32'd0);

        // Backpressure on slot 3
        periph_rx_ready[3] = 1'b0;
        usb_rx_data  = 32'h6000_00AA;
        usb_rx_valid = 1'b1;
        tick();
        usb_rx_data = 32'h2000_0055;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_rx_ready", 32'(usb_rx_ready), 32'd0);
            check("bp_rx_valid", 32'(periph_rx_valid), 32'h08);
            check("bp_rx_data", periph_rx_data, 32'h6000_00AA);
            tick();
        end
        periph_rx_ready[3] = 1'b1;
        #1;
        check("bp_release_rx_ready", 32'(usb_rx_ready), 32'd1);
        tick();
        check("bp_next_valid", 32'(periph_rx_valid), 32'h02);
        check("bp_next_data", periph_rx_data, 32'h2000_0055);
        usb_rx_valid = 1'b0;
        tick();

        // Disabled slot 5: 300 packets dropped, counter saturates
        periph_en[5] = 1'b0;
        usb_rx_valid = 1'b1;
        for (int p = 1; p <= 300; p++) begin
            usb_rx_data = 32'hA000_0000 | 32'(p);
            #1;
            check("drop_rx_ready", 32'(usb_rx_ready), 32'd1);
            check("drop_rx_valid", 32'(periph_rx_valid), 32'd0);
            tick();
            if (p == 100) check("drop_count_100", 32'(drop_count), 32'd99);
            if (p == 256) check("drop_count_256", 32'(drop_count), 32'd255);
        end
        usb_rx_valid = 1'b0;
        tick();
        check("drop_count_sat", 32'(drop_count), 32'd255);
        periph_en[5] = 1'b1;

        // Round robin with all slots requesting
        periph_tx_valid = 8'hFF;
        usb_tx_ready    = 1'b1;
        for (int k = 0; k <= N; k++) begin
            #1;
            check("rr_grant", 32'(periph_tx_ready), 32'(8'h01 << (k % N)));
            tick();
            check("rr_tx_valid", 32'(usb_tx_valid), 32'd1);
            check("rr_tx_data", usb_tx_data, tx_stamped(k % N));
            check("rr_tx_addr", 32'(usb_tx_data[31:29]), 32'(k % N));
        end
        periph_tx_valid = 8'h00;
        #1;
        check("rr_idle_ready", 32'(periph_tx_ready), 32'd0);
        tick();
        check("rr_idle_valid", 32'(usb_tx_valid), 32'd0);

        // Slot 2 all-ones word, host not ready
        periph_tx_data[2*W +: W] = 32'hFFFF_FFFF;
        periph_tx_valid = 8'h04;
        usb_tx_ready    = 1'b0;
        #1;
        check("s2_grant", 32'(periph_tx_ready), 32'h04);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("s2_tx_data", usb_tx_data, 32'h5FFF_FFFF);
            check("s2_tx_valid", 32'(usb_tx_valid), 32'd1);
            check("s2_stall_ready", 32'(periph_tx_ready), 32'd0);
            tick();
        end
        periph_tx_valid = 8'h00;
        usb_tx_ready    = 1'b1;
        tick();
        check("s2_drained", 32'(usb_tx_valid), 32'd0);

        // Reset mid-burst on both paths
        periph_rx_ready[4] = 1'b0;
        usb_rx_data     = 32'h8000_0123;
        usb_rx_valid    = 1'b1;
        periph_tx_valid = 8'hFF;
        usb_tx_ready    = 1'b0;
        tick();
        check("mid_rx_valid", 32'(periph_rx_valid), 32'h10);
        check("mid_tx_valid", 32'(usb_tx_valid), 32'd1);
        check("mid_tx_addr", 32'(usb_tx_data[31:29]), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(usb_tx_valid), 32'd0);
        check("mid_rst_rx_valid", 32'(periph_rx_valid), 32'd0);
        check("mid_rst_rx_ready", 32'(usb_rx_ready), 32'd0);
        check("mid_rst_tx_ready", 32'(periph_tx_ready), 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        usb_rx_valid       = 1'b0;
        periph_rx_ready[4] = 1'b1;
        usb_tx_ready       = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        check("post_mid_rx_ready", 32'(usb_rx_ready), 32'd1);
        check("post_mid_grant", 32'(periph_tx_ready), 32'h01);
        tick();
        check("post_mid_tx_addr", 32'(usb_tx_data[31:29]), 32'd0);
        check("post_mid_tx_valid", 32'(usb_tx_valid), 32'd1);
        check("post_mid_drop", 32'(drop_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_packet_router.md
# periph_packet_router

Routes 32-bit USB packets between the host FIFO interface and the peripheral slots. Downstream, it decodes the peripheral address field of each host packet and delivers the packet to the addressed peripheral. Upstream, it round-robin arbitrates the peripherals' outbound packets into the single USB TX stream, stamping each with its source address. It sits directly between the USB FIFO bridge and the peripheral array, and is sized by the global peripheral count and packet width.

## Interface
- NUM_PERIPH, 8, number of peripheral slots
- PKT_W, 32, packet width (USB word)
- ADDR_W, $clog2(NUM_PERIPH) = 3, address field width, packet bits [PKT_W-1 -: ADDR_W]

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- usb_rx_data  in  PKT_W  host→device packet
- usb_rx_valid  in  1  host packet valid
- usb_rx_ready  out  1  router accepts host packet
- periph_en  in  NUM_PERIPH  per-slot enable; packets to disabled slots are dropped
- periph_rx_data  out  PKT_W  packet broadcast to all slots, unmodified
- periph_rx_valid  out  NUM_PERIPH  one-hot valid to the addressed slot
- periph_rx_ready  in  NUM_PERIPH  per-slot accept
- periph_tx_data  in  NUM_PERIPH*PKT_W  slot i occupies bits [i*PKT_W +: PKT_W]
- periph_tx_valid  in  NUM_PERIPH  per-slot outbound request
- periph_tx_ready  out  NUM_PERIPH  one-hot grant/accept
- usb_tx_data  out  PKT_W  device→host packet
- usb_tx_valid  out  1  device packet valid
- usb_tx_ready  in  1  USB bridge accepts packet
- drop_count  out  8  saturating count of dropped host packets

## Operation
- A transfer occurs on any valid/ready pair when both are high at a rising clk edge. Valid, once asserted, must not drop until the transfer occurs; the router meets this rule on all of its outputs.
- RX path: one holding register, rx_full/rx_buf.
  - dest = rx_buf[PKT_W-1 -: ADDR_W].
  - periph_rx_valid[dest] = rx_full & periph_en[dest]; all other bits are 0.
  - rx_drain = rx_full & (~periph_en[dest] | periph_rx_ready[dest]).
  - usb_rx_ready = ~rx_full | rx_drain. This is a combinational path from periph_rx_ready and periph_en; it gives full throughput.
  - Drain and accept in the same cycle: the buffer reloads with the new packet and rx_full stays 1.
  - Drain with a disabled dest: the packet is discarded and drop_count increments, saturating at 255 with no wrap.
  - periph_en is sampled every cycle. If a slot is disabled while its packet is pending, the packet is dropped on that cycle.
- TX path: one output register, tx_full/tx_buf, plus a round-robin pointer last_grant.
  - tx_free = ~tx_full | usb_tx_ready.
  - When tx_free is high and any periph_tx_valid bit is set, grant the first requester searching upward from last_grant+1 mod NUM_PERIPH.
  - periph_tx_ready = one-hot grant; it is 0 whenever tx_free is low.
  - On a grant to slot i: tx_buf <= {i[ADDR_W-1:0], periph_tx_data_i[PKT_W-ADDR_W-1:0]}, tx_full <= 1, last_grant <= i.
  - tx_free with no requester: tx_full <= 0 if the register drained.
  - TX requests are not masked by periph_en.
- The RX and TX paths are independent and operate concurrently.

## Timing
- Reset (rst_n low, asynchronous):
  - rx_full = 0 and tx_full = 0.
  - last_grant = NUM_PERIPH-1, so slot 0 has first priority.
  - drop_count = 0; usb_tx_valid = 0; periph_rx_valid = 0.
  - usb_rx_ready and periph_tx_ready are forced to 0 while rst_n is low.
- After reset release: usb_rx_ready = 1 on the first cycle.
- RX latency: a packet accepted at edge N drives periph_rx_valid from cycle N+1. Sustained throughput is 1 packet/cycle when the destination is ready.
- TX latency: a packet granted at edge N drives usb_tx_valid from cycle N+1. Sustained throughput is 1 packet/cycle when usb_tx_ready is high.
- Reset asserted mid-transfer: buffered packets are lost. No partial state survives.

## Test plan
- Send host packets with addr 0..7 (all slots enabled, all ready) back-to-back → each appears 1 cycle later on the matching one-hot periph_rx_valid; data is unmodified; usb_rx_ready stays 1; 8 packets complete in 9 cycles.
- Hold periph_rx_ready[3]=0 with packet 0x6000_00AA (addr 3) pending for 5 cycles → usb_rx_ready=0 and data is stable for 5 cycles; release ready → transfer occurs and the next host packet is accepted in the same cycle.
- Set periph_en[5]=0 and send 300 packets to addr 5 → no periph_rx_valid pulses, one accepted per cycle, drop_count saturates at 255.
- Hold periph_tx_valid = 8'hFF continuously with usb_tx_ready=1 → grants occur in order 0,1,…,7,0; usb_tx_data[31:29] equals the granted index in each case.
- Slot 2 sends 0xFFFF_FFFF → usb_tx_data = 0x5FFF_FFFF (address stamped to 2). With usb_tx_ready=0, periph_tx_ready stays 0 after the register fills.
- Assert rst_n low mid-burst on both paths → all valids and readys go to 0 immediately; after release, slot 0 wins the first TX arbitration and drop_count reads 0.
